// File: rtl/clk_gate_ctrl.sv
// =============================================================================
// clk_gate_ctrl
// -----------------------------------------------------------------------------
// Drives the enable pin of the shared clock buffer/gate for a gated clock
// domain, and grants NUM_REQ requesters access to that clock.
//
// The block wakes the buffer up, then waits a settle delay before it grants
// anyone. While requests are present it grants every active requester at
// once. Once requests stop, it keeps the clock running for an idle grace
// period before it gates the buffer off. A new request during that grace
// period is granted immediately, without a new settle delay.
//
// Optional build macro:
//   CLK_GATE_STATS_EN - adds the wake_count output, a saturating count of
//                       OFF->WAKE transitions. When undefined, the port and
//                       the counter are absent and the rest is unchanged.
//
// Parameters:
//   NUM_REQ      number of requesters
//   WAKE_CYCLES  edges clk_en is high before the first ack (>= 1)
//   IDLE_CYCLES  edges with no request before clk_en drops (>= 1)
//   CNT_W        width of wake_count (stats build only)
//
// Ports:
//   clk_in      in   1        free-running source clock
//   rst_n       in   1        asynchronous active-low reset
//   req         in   NUM_REQ  level request per requester
//   force_on    in   1        hold the gated clock on; never acked
//   ack         out  NUM_REQ  registered grant; gated clock running while high
//   clk_en      out  1        registered enable to the clock buffer/gate
//   busy        out  1        registered; high whenever the FSM is not OFF
//   wake_count  out  CNT_W    OFF->WAKE transition count (stats build only)
// =============================================================================
module clk_gate_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    output logic [NUM_REQ-1:0] ack,
    output logic               clk_en,
    output logic               busy
`ifdef CLK_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0]   wake_count
`endif
);

    // One down-counter serves both the settle delay and the idle timeout, so
    // it is sized for the larger of the two.
    localparam int MAX_CYCLES = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
    localparam int CNT_BITS   = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_BITS-1:0] WAKE_LOAD = CNT_BITS'(WAKE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] IDLE_LOAD = CNT_BITS'(IDLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    generate
        if (NUM_REQ < 1 || WAKE_CYCLES < 1 || IDLE_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
            $error("clk_gate_ctrl: NUM_REQ, WAKE_CYCLES, IDLE_CYCLES and CNT_W must all be >= 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_next;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_next;
    logic                r_clk_en;
    logic                w_clk_en_next;
    logic                r_busy;
    logic                w_busy_next;

    // w_grant marks edges on which the FSM is (or lands) in ON; only then may
    // the ack register pick up the current requests.
    logic                w_grant;
    logic                w_any;
    logic                w_cnt_zero;

    assign w_any      = (|req) | force_on;
    assign w_cnt_zero = (r_cnt == '0);

    // Each grant bit simply follows its own request while granting is allowed.
    // Requesters are independent; none of them waits on another.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack_next
            assign w_ack_next[gi] = req[gi] & w_grant;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_OFF;
            r_cnt    <= '0;
            r_ack    <= '0;
            r_clk_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_ack    <= w_ack_next;
            r_clk_en <= w_clk_en_next;
            r_busy   <= w_busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_clk_en_next = r_clk_en;
        w_busy_next   = r_busy;
        w_grant       = 1'b0;

        unique case (r_state)
            S_OFF: begin
                if (w_any) begin
                    w_state_next  = S_WAKE;
                    w_clk_en_next = 1'b1;
                    w_busy_next   = 1'b1;
                    w_cnt_next    = WAKE_LOAD;
                end
            end

            // The settle delay always runs to completion: the buffer has
            // already been enabled, so a request that vanishes meanwhile
            // does not cut the wake short.
            S_WAKE: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_state_next = S_ON;
                    w_grant      = 1'b1;
                end
            end

            // Acks are dropped on the same edge as IDLE entry, so clk_en can
            // only fall later, with every ack already low.
            S_ON: begin
                if (w_any) begin
                    w_grant = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = IDLE_LOAD;
                end
            end

            // The clock is still running here, so a returning request is
            // granted at once with no settle penalty.
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_ON;
                    w_grant      = 1'b1;
                end else if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_state_next  = S_OFF;
                    w_clk_en_next = 1'b0;
                    w_busy_next   = 1'b0;
                end
            end

            default: begin
                w_state_next  = S_OFF;
                w_cnt_next    = '0;
                w_clk_en_next = 1'b0;
                w_busy_next   = 1'b0;
            end
        endcase
    end

    assign ack    = r_ack;
    assign clk_en = r_clk_en;
    assign busy   = r_busy;

    // -------------------------------------------------------------------------
    // Optional wake statistics
    // -------------------------------------------------------------------------
`ifdef CLK_GATE_STATS_EN
    logic             w_wake_evt;
    logic [CNT_W-1:0] r_wake_count;

    assign w_wake_evt = (r_state == S_OFF) && w_any;

    // Saturates instead of wrapping so a long-running count stays a valid
    // lower bound.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wake_count <= '0;
        end else if (w_wake_evt && (r_wake_count != '1)) begin
            r_wake_count <= r_wake_count + 1'b1;
        end
    end

    assign wake_count = r_wake_count;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

    localparam int NUM_REQ = 4;
    localparam int WAKE    = 2;
    localparam int IDLE    = 8;
    localparam int CNT_W   = 16;

    logic               clk_in = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic               force_on;
    logic [NUM_REQ-1:0] ack;
    logic               clk_en;
    logic               busy;
`ifdef CLK_GATE_STATS_EN
    logic [CNT_W-1:0]   wake_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    clk_gate_ctrl #(
        .NUM_REQ    (NUM_REQ),
        .WAKE_CYCLES(WAKE),
        .IDLE_CYCLES(IDLE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .req     (req),
        .force_on(force_on),
        .ack     (ack),
        .clk_en  (clk_en),
        .busy    (busy)
`ifdef CLK_GATE_STATS_EN
        ,
        .wake_count(wake_count)
`endif
    );

    // ------------------------------------------------------------------
    // Behavioural reference: the clock is either off, settling (counting
    // edges since wake-up), or granted (counting consecutive quiet edges).
    // ------------------------------------------------------------------
    bit                 m_en;
    bit                 m_granted;
    int                 m_wake_left;
    int                 m_quiet;
    logic [NUM_REQ-1:0] m_ack;
    longint             m_wakes;

    function automatic void model_reset();
        m_en        = 1'b0;
        m_granted   = 1'b0;
        m_wake_left = 0;
        m_quiet     = 0;
        m_ack       = '0;
        m_wakes     = 0;
    endfunction

    function automatic void model_step(input logic [NUM_REQ-1:0] r, input logic f);
        bit any;
        any = (r != 0) || f;
        if (!m_en) begin
            if (any) begin
                m_en        = 1'b1;
                m_granted   = 1'b0;
                m_wake_left = WAKE;
                m_ack       = '0;
                if (m_wakes < (64'd1 << CNT_W) - 1) m_wakes++;
            end
        end else if (!m_granted) begin
            m_wake_left--;
            if (m_wake_left == 0) begin
                m_granted = 1'b1;
                m_ack     = r;
                m_quiet   = 0;
            end
        end else if (any) begin
            m_ack   = r;
            m_quiet = 0;
        end else begin
            // Quiet edge number IDLE+1 (counting the one that left ON) gates off.
            m_ack = '0;
            m_quiet++;
            if (m_quiet > IDLE) begin
                m_en      = 1'b0;
                m_granted = 1'b0;
            end
        end
    endfunction

    // One rising edge; inputs are stable across it, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk_in);
        model_step(req, force_on);
        #1;
    endtask

    task automatic apply_reset();
        req      = '0;
        force_on = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #4;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 4'b1111;
        force_on = 1'b1;
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        checks++;
        if (clk_en !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: got clk_en=%b busy=%b ack=%b expected 0 0 0000", clk_en, busy, ack);
        end
`ifdef CLK_GATE_STATS_EN
        checks++;
        if (wake_count !== '0) begin
            failures++;
            $display("FAIL reset_wake_count: got %0d expected 0", wake_count);
        end
`endif
        apply_reset();
        $display("test_reset done");
    endtask

    task automatic test_cold_wake();
        apply_reset();
        req = 4'b0001;
        tick();
        checks++;
        if (clk_en !== 1'b1 || busy !== 1'b1 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL cold_wake_edge1: got clk_en=%b busy=%b ack=%b expected 1 1 0000", clk_en, busy, ack);
        end
        tick();
        checks++;
        if (ack !== 4'b0000 || clk_en !== 1'b1) begin
            failures++;
            $display("FAIL cold_wake_edge2: got clk_en=%b ack=%b expected 1 0000", clk_en, ack);
        end
        tick();
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cold_wake_edge3: got ack=%b busy=%b expected 0001 1", ack, busy);
        end
        $display("test_cold_wake done");
    endtask

    // Starts in ON with req=0001 (follows test_cold_wake).
    task automatic test_idle_off();
        int fall_edge;
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0000 || clk_en !== 1'b1) begin
            failures++;
            $display("FAIL idle_entry: got ack=%b clk_en=%b expected 0000 1", ack, clk_en);
        end
        fall_edge = -1;
        for (int i = 1; i <= 12 && fall_edge < 0; i++) begin
            tick();
            if (clk_en === 1'b0) fall_edge = i;
        end
        checks++;
        if (fall_edge != IDLE) begin
            failures++;
            $display("FAIL idle_off_delay: got clk_en fall %0d edges after idle entry expected %0d", fall_edge, IDLE);
        end
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL idle_off_busy: got busy=%b ack=%b expected 0 0000", busy, ack);
        end
        $display("test_idle_off done");
    endtask

    task automatic test_idle_rescue();
        bit dropped;
        apply_reset();
        req = 4'b0001;
        repeat (3) tick();
        req = 4'b0000;
        tick();                      // IDLE entry
        dropped = (clk_en !== 1'b1);
        repeat (3) begin
            tick();
            if (clk_en !== 1'b1) dropped = 1'b1;
        end
        req = 4'b0100;
        tick();
        checks++;
        if (ack !== 4'b0100) begin
            failures++;
            $display("FAIL idle_rescue_ack: got %b expected 0100", ack);
        end
        repeat (IDLE + 2) begin
            tick();
            if (clk_en !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            failures++;
            $display("FAIL idle_rescue_clk_en: got a clk_en drop expected clk_en held 1");
        end
        $display("test_idle_rescue done");
    endtask

    // Starts in ON with req=0100 (follows test_idle_rescue).
    task automatic test_multi_request();
        req = 4'b1011;
        tick();
        checks++;
        if (ack !== 4'b1011) begin
            failures++;
            $display("FAIL multi_req_all: got %b expected 1011", ack);
        end
        req = 4'b1001;
        tick();
        checks++;
        if (ack !== 4'b1001) begin
            failures++;
            $display("FAIL multi_req_drop: got %b expected 1001", ack);
        end
        req = 4'b0000;
        repeat (IDLE + 1) tick();
        checks++;
        if (clk_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL multi_req_off: got clk_en=%b busy=%b expected 0 0", clk_en, busy);
        end
        $display("test_multi_request done");
    endtask

    task automatic test_force_on();
        bit acked;
        int fall_edge;
        apply_reset();
        force_on = 1'b1;
        tick();
        checks++;
        if (clk_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL force_on_wake: got clk_en=%b busy=%b expected 1 1", clk_en, busy);
        end
        acked = (ack !== 4'b0000);
        repeat (6) begin
            tick();
            if (ack !== 4'b0000) acked = 1'b1;
        end
        checks++;
        if (acked) begin
            failures++;
            $display("FAIL force_on_ack: got a nonzero ack expected ack 0000 throughout");
        end
        force_on  = 1'b0;
        fall_edge = -1;
        for (int i = 1; i <= 20 && fall_edge < 0; i++) begin
            tick();
            if (clk_en === 1'b0) fall_edge = i;
        end
        checks++;
        if (fall_edge != IDLE + 1) begin
            failures++;
            $display("FAIL force_on_off_delay: got %0d edges expected %0d", fall_edge, IDLE + 1);
        end
        $display("test_force_on done");
    endtask

    task automatic test_reset_mid_on();
        apply_reset();
        req = 4'b0011;
        repeat (3) tick();
        checks++;
        if (ack !== 4'b0011) begin
            failures++;
            $display("FAIL mid_on_ack: got %b expected 0011", ack);
        end
`ifdef CLK_GATE_STATS_EN
        checks++;
        if (wake_count !== CNT_W'(1)) begin
            failures++;
            $display("FAIL mid_on_wake_count_before: got %0d expected 1", wake_count);
        end
`endif
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (clk_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_on_async_reset: got clk_en=%b ack=%b busy=%b expected 0 0000 0", clk_en, ack, busy);
        end
`ifdef CLK_GATE_STATS_EN
        checks++;
        if (wake_count !== '0) begin
            failures++;
            $display("FAIL mid_on_wake_count_after: got %0d expected 0", wake_count);
        end
`endif
        req = 4'b0000;
        #2;
        rst_n = 1'b1;
        $display("test_reset_mid_on done");
    endtask

    // Random bursts of activity separated by quiet gaps of varying length,
    // so idle rescues at every counter value and full gate-offs all occur.
    task automatic test_random();
        int errs;
        int n;
        errs = 0;
        n    = 0;
        apply_reset();
        for (int seg = 0; seg < 120; seg++) begin
            int  act_len;
            int  quiet_len;
            bit  use_force;
            act_len   = $urandom_range(20, 1);
            quiet_len = $urandom_range(14, 0);
            use_force = ($urandom_range(3, 0) == 0);
            for (int c = 0; c < act_len + quiet_len; c++) begin
                if (c < act_len) begin
                    if ($urandom_range(3, 0) == 0) req = NUM_REQ'($urandom);
                    force_on = use_force;
                end else begin
                    req      = '0;
                    force_on = 1'b0;
                end
                tick();
                n++;
                checks++;
                if (ack !== m_ack || clk_en !== m_en || busy !== m_en) begin
                    failures++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random_cycle%0d: got ack=%b clk_en=%b busy=%b expected ack=%b clk_en=%b busy=%b",
                                 n, ack, clk_en, busy, m_ack, m_en, m_en);
                end
`ifdef CLK_GATE_STATS_EN
                checks++;
                if (wake_count !== CNT_W'(m_wakes)) begin
                    failures++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random_wake_count%0d: got %0d expected %0d", n, wake_count, m_wakes);
                end
`endif
            end
        end
        $display("test_random done: %0d cycles, %0d wakes", n, m_wakes);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        force_on = 1'b0;
        test_reset();
        test_cold_wake();
        test_idle_off();
        test_idle_rescue();
        test_multi_request();
        test_force_on();
        test_reset_mid_on();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
